// File: rtl/led_pkg.sv
// led_pkg: shared mode and channel-state encodings for the LED pattern engine
package led_pkg;
  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_t;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SOLID  = 2'd1,
    ST_PH_ON  = 2'd2,
    ST_PH_OFF = 2'd3
  } ch_state_t;
endpackage

// File: rtl/led_channel.sv
// led_channel: one LED channel FSM (clk/rst_n, tick, pwm_cnt, we+mode/half/count/bright config in; led/busy/done registered out)
module led_channel
  import led_pkg::*;
#(
  parameter int PERIOD_W = 16,
  parameter int COUNT_W  = 8,
  parameter int PWM_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic [PWM_W-1:0]    pwm_cnt,
  input  logic                we,
  input  mode_t               mode,
  input  logic [PERIOD_W-1:0] half,
  input  logic [COUNT_W-1:0]  count,
  input  logic [PWM_W-1:0]    bright,
  output logic                led,
  output logic                busy,
  output logic                done
);
  ch_state_t st, st_n;
  logic [PERIOD_W-1:0] timer, timer_n, half_q, half_n, half_v;
  logic [COUNT_W-1:0] remain, remain_n;
  logic [PWM_W-1:0] bright_q, bright_n;
  logic burst, burst_n, done_n, pwm_on;
  assign half_v = (half == '0) ? PERIOD_W'(1) : half;
  assign pwm_on = (&bright_q) | (pwm_cnt < bright_q);
  always_comb begin
    st_n     = st;
    timer_n  = timer;
    half_n   = half_q;
    remain_n = remain;
    bright_n = bright_q;
    burst_n  = burst;
    done_n   = 1'b0;
    if (we) begin
      half_n   = half_v;
      timer_n  = half_v;
      remain_n = count;
      bright_n = bright;
      burst_n  = mode == MODE_BURST;
      done_n   = mode == MODE_BURST && count == '0;
      st_n     = mode == MODE_OFF ? ST_IDLE :
                 mode == MODE_ON ? ST_SOLID :
                 (mode == MODE_BURST && count == '0) ? ST_IDLE : ST_PH_ON;
    end else if (tick && (st == ST_PH_ON || st == ST_PH_OFF)) begin
      if (timer != PERIOD_W'(1)) begin
        timer_n = timer - 1'b1;
      end else if (st == ST_PH_ON) begin
        st_n    = ST_PH_OFF;
        timer_n = half_q;
      end else if (burst && remain == COUNT_W'(1)) begin
        st_n   = ST_IDLE;
        done_n = 1'b1;
      end else begin
        st_n     = ST_PH_ON;
        timer_n  = half_q;
        remain_n = burst ? remain - 1'b1 : remain;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= ST_IDLE;
      timer    <= '0;
      half_q   <= '0;
      remain   <= '0;
      bright_q <= '0;
      burst    <= 1'b0;
      led      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      st       <= st_n;
      timer    <= timer_n;
      half_q   <= half_n;
      remain   <= remain_n;
      bright_q <= bright_n;
      burst    <= burst_n;
      led      <= (st == ST_SOLID || st == ST_PH_ON) && pwm_on;
      busy     <= st != ST_IDLE;
      done     <= done_n;
    end
  end
endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: multi-channel LED pattern engine (clk/rst_n, cfg_* valid/ready config port in; led/busy/done per channel out)
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CLK_HZ   = 27_000_000,
  parameter int TICK_HZ  = 1000,
  parameter int PERIOD_W = 16,
  parameter int COUNT_W  = 8,
  parameter int PWM_W    = 8,
  localparam int CH_W    = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [PERIOD_W-1:0] cfg_half,
  input  logic [COUNT_W-1:0]  cfg_count,
  input  logic [PWM_W-1:0]    cfg_bright,
  output logic [NUM_CH-1:0]   led,
  output logic [NUM_CH-1:0]   busy,
  output logic [NUM_CH-1:0]   done
);
  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int DIV_W = $clog2(DIV);
  logic [DIV_W-1:0] pre;
  logic [PWM_W-1:0] pwm_cnt;
  logic tick;
  assign tick = pre == DIV_W'(DIV - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre       <= '0;
      pwm_cnt   <= '0;
      cfg_ready <= 1'b0;
    end else begin
      pre       <= tick ? '0 : pre + 1'b1;
      pwm_cnt   <= pwm_cnt + 1'b1;
      cfg_ready <= 1'b1;
    end
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    led_channel #(
      .PERIOD_W(PERIOD_W),
      .COUNT_W (COUNT_W),
      .PWM_W   (PWM_W)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick   (tick),
      .pwm_cnt(pwm_cnt),
      .we     (cfg_valid && cfg_ready && cfg_ch == CH_W'(i)),
      .mode   (mode_t'(cfg_mode)),
      .half   (cfg_half),
      .count  (cfg_count),
      .bright (cfg_bright),
      .led    (led[i]),
      .busy   (busy[i]),
      .done   (done[i])
    );
  end
endmodule
